// File: rtl/sdram_arb_pkg.sv
// Shared widths, FSM state encoding and request-slot layout for the SDRAM arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              pending;
  } req_slot_t;

endpackage

// File: rtl/arb_req_slot.sv
// One-entry request latch. A strobe that lands after the grant is kept pending
// across the completion of the request it raced with.
module arb_req_slot
  import sdram_arb_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              i_strobe,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  input  logic              i_clear,
  output req_slot_t         o_slot,
  output logic              o_ovf
);

  req_slot_t r_slot;
  logic      r_fresh;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_slot  <= '0;
      r_fresh <= 1'b0;
    end else begin
      if (i_strobe) begin
        r_slot.addr    <= i_addr;
        r_slot.data    <= i_data;
        r_slot.pending <= 1'b1;
      end else if (i_clear) begin
        r_slot.pending <= r_fresh;
      end
      // A strobe in the grant cycle is consumed by that grant via the top's bypass.
      if (i_grant) begin
        r_fresh <= 1'b0;
      end else if (i_strobe) begin
        r_fresh <= 1'b1;
      end
    end
  end

  assign o_slot = r_slot;
  // The cycle that completes the held request frees the slot, so it is not an overflow.
  assign o_ovf  = i_strobe & r_slot.pending & ~i_clear;

endmodule

// File: rtl/sdram_arb.sv
// Shares the byte-wide SDRAM port between loader writes and VFD reads with
// bounded loader bursts and an ack watchdog.
module sdram_arb
  import sdram_arb_pkg::*;
#(
  parameter int unsigned LD_BURST = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ld_wr,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_wait,
  input  logic              vfd_rd,
  input  logic [ADDR_W-1:0] vfd_addr,
  output logic [DATA_W-1:0] vfd_data,
  output logic              vfd_valid,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic              sd_we,
  output logic              sd_rd,
  input  logic [DATA_W-1:0] sd_dout,
  input  logic              sd_ack,
  output logic              err_ovf,
  output logic              err_tmo
);

  localparam int unsigned BURST_W = $clog2(LD_BURST + 1);
  localparam int unsigned WDOG_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(LD_BURST);
  localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  logic [BURST_W-1:0] r_burst;
  logic [WDOG_W-1:0]  r_wdog;
  logic [ADDR_W-1:0]  r_sd_addr;
  logic [DATA_W-1:0]  r_sd_din;
  logic               r_sd_we;
  logic               r_sd_rd;
  logic [DATA_W-1:0]  r_vfd_data;
  logic               r_vfd_valid;
  logic               r_err_ovf;
  logic               r_err_tmo;

  req_slot_t w_ld_slot;
  req_slot_t w_vfd_slot;
  logic      w_ld_ovf;
  logic      w_vfd_ovf;
  logic      w_ld_grant;
  logic      w_vfd_grant;
  logic      w_wdog_hit;
  logic      w_ld_clear;
  logic      w_vfd_clear;
  logic      w_unused_vfd;

  assign w_ld_grant  = (r_state == IDLE) && w_ld_slot.pending &&
                       !(w_vfd_slot.pending && (r_burst == BURST_MAX));
  assign w_vfd_grant = (r_state == IDLE) && w_vfd_slot.pending && !w_ld_grant;
  assign w_wdog_hit  = (r_wdog == WDOG_LAST);
  assign w_ld_clear  = (r_state == WR_WAIT) && (sd_ack || w_wdog_hit);
  assign w_vfd_clear = (r_state == RD_WAIT) && (sd_ack || w_wdog_hit);

  arb_req_slot u_ld_slot (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_strobe (ld_wr),
    .i_addr   (ld_addr),
    .i_data   (ld_data),
    .i_grant  (w_ld_grant),
    .i_clear  (w_ld_clear),
    .o_slot   (w_ld_slot),
    .o_ovf    (w_ld_ovf)
  );

  arb_req_slot u_vfd_slot (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .i_strobe (vfd_rd),
    .i_addr   (vfd_addr),
    .i_data   ('0),
    .i_grant  (w_vfd_grant),
    .i_clear  (w_vfd_clear),
    .o_slot   (w_vfd_slot),
    .o_ovf    (w_vfd_ovf)
  );

  assign w_unused_vfd = ^{w_vfd_slot.data, w_vfd_ovf};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state     <= IDLE;
      r_burst     <= '0;
      r_wdog      <= '0;
      r_sd_addr   <= '0;
      r_sd_din    <= '0;
      r_sd_we     <= 1'b0;
      r_sd_rd     <= 1'b0;
      r_vfd_data  <= '0;
      r_vfd_valid <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_err_tmo   <= 1'b0;
    end else begin
      r_sd_we     <= 1'b0;
      r_sd_rd     <= 1'b0;
      r_vfd_valid <= 1'b0;
      if (w_ld_ovf) r_err_ovf <= 1'b1;

      unique case (r_state)
        IDLE: begin
          if (!w_vfd_slot.pending) r_burst <= '0;
          // Strobes in the grant cycle bypass the slot so the newest request is issued.
          if (w_ld_grant) begin
            r_state   <= WR_ISSUE;
            r_sd_we   <= 1'b1;
            r_sd_addr <= ld_wr ? ld_addr : w_ld_slot.addr;
            r_sd_din  <= ld_wr ? ld_data : w_ld_slot.data;
            if (w_vfd_slot.pending) r_burst <= r_burst + 1'b1;
          end else if (w_vfd_grant) begin
            r_state   <= RD_ISSUE;
            r_sd_rd   <= 1'b1;
            r_sd_addr <= vfd_rd ? vfd_addr : w_vfd_slot.addr;
            r_burst   <= '0;
          end
        end
        WR_ISSUE: begin
          r_state <= WR_WAIT;
          r_wdog  <= '0;
        end
        RD_ISSUE: begin
          r_state <= RD_WAIT;
          r_wdog  <= '0;
        end
        WR_WAIT: begin
          if (sd_ack) begin
            r_state <= IDLE;
          end else if (w_wdog_hit) begin
            r_state   <= IDLE;
            r_err_tmo <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        RD_WAIT: begin
          if (sd_ack) begin
            r_state     <= IDLE;
            r_vfd_data  <= sd_dout;
            r_vfd_valid <= 1'b1;
          end else if (w_wdog_hit) begin
            r_state     <= IDLE;
            r_vfd_data  <= '0;
            r_vfd_valid <= 1'b1;
            r_err_tmo   <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ld_wait   = w_ld_slot.pending;
  assign vfd_data  = r_vfd_data;
  assign vfd_valid = r_vfd_valid;
  assign sd_addr   = r_sd_addr;
  assign sd_din    = r_sd_din;
  assign sd_we     = r_sd_we;
  assign sd_rd     = r_sd_rd;
  assign err_ovf   = r_err_ovf;
  assign err_tmo   = r_err_tmo;

endmodule
